// File: rtl/signed_mult_pkg.sv
// signed_mult_pkg: shared types and helpers for the signed multiply sequencer.
package signed_mult_pkg;

  localparam int N_DEFAULT = 16;
  // Working width of abs_n; callers zero-extend N-bit operands into it.
  localparam int ABS_W     = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Conditional two's-complement negate; the low N bits of the result are
  // the magnitude of an N-bit operand whose sign bit is take_neg.
  function automatic logic [ABS_W-1:0] abs_n(input logic [ABS_W-1:0] x,
                                             input logic             take_neg);
    abs_n = take_neg ? (~x + ABS_W'(1)) : x;
  endfunction

endpackage

// File: rtl/sign_fix.sv
// sign_fix: combinational conditional negate of a W-bit product.
// A zero input stays zero when negated, so no negative zero appears.
module sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] x,
  input  logic         neg,
  output logic [W-1:0] y
);

  // Two's-complement negate when neg is set, pass-through otherwise.
  always_comb y = neg ? (~x + W'(1)) : x;

endmodule

// File: rtl/signed_mult_ctrl.sv
// signed_mult_ctrl: wraps an unsigned N x N shift-add core so the CPU can
// issue signed or unsigned multiplies. Operands become magnitudes, the core
// runs, and the sign is re-applied to the 2N-bit product.
// Optional: define SIGNED_MULT_TIMEOUT_EN to add a WAIT watchdog and err out.
module signed_mult_ctrl
  import signed_mult_pkg::*;
#(
  parameter int N = N_DEFAULT
`ifdef SIGNED_MULT_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 4*N+8
`endif
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ena,
  input  logic           start,
  input  logic           signed_op,
  input  logic [2*N-1:0] dataA,
  input  logic [2*N-1:0] dataB,
  output logic [2*N-1:0] res,
  output logic           done,
  output logic           busy,
`ifdef SIGNED_MULT_TIMEOUT_EN
  output logic           err,
`endif
  output logic           mul_start,
  output logic [2*N-1:0] mul_dataA,
  output logic [2*N-1:0] mul_dataB,
  input  logic [2*N-1:0] mul_res,
  input  logic           mul_rdy
);

  state_t         state_q, state_d;
  logic           neg_q, neg_d;
  logic [2*N-1:0] res_q, res_d;
  logic           done_q, done_d;
  logic           busy_q, busy_d;
  logic           mul_start_q, mul_start_d;
  logic [N-1:0]   mul_a_q, mul_a_d;
  logic [N-1:0]   mul_b_q, mul_b_d;
`ifdef SIGNED_MULT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES+1);
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           err_q, err_d;
`endif

  logic [N-1:0]   a_lo, b_lo, mag_a, mag_b;
  logic           sign_a, sign_b;
  logic [2*N-1:0] res_fixed;
  logic           unused_hi;

  assign a_lo      = dataA[N-1:0];
  assign b_lo      = dataB[N-1:0];
  // Upper operand halves carry no meaning for this block.
  assign unused_hi = ^{dataA[2*N-1:N], dataB[2*N-1:N]};

  // Operand signs (only in signed mode) and their magnitudes.
  always_comb begin
    sign_a = signed_op & a_lo[N-1];
    sign_b = signed_op & b_lo[N-1];
    mag_a  = N'(abs_n(ABS_W'(a_lo), sign_a));
    mag_b  = N'(abs_n(ABS_W'(b_lo), sign_b));
  end

  sign_fix #(.W(2*N)) u_sign_fix (
    .x   (mul_res),
    .neg (neg_q),
    .y   (res_fixed)
  );

  // Next-state and registered-output logic; everything holds while ena is low.
  always_comb begin
    state_d     = state_q;
    neg_d       = neg_q;
    res_d       = res_q;
    done_d      = done_q;
    busy_d      = busy_q;
    mul_start_d = mul_start_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
`ifdef SIGNED_MULT_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
`endif
    if (ena) begin
      done_d      = 1'b0;
      mul_start_d = 1'b0;
`ifdef SIGNED_MULT_TIMEOUT_EN
      err_d       = 1'b0;
`endif
      case (state_q)
        IDLE: if (start) begin
          mul_a_d     = mag_a;
          mul_b_d     = mag_b;
          neg_d       = sign_a ^ sign_b;
          busy_d      = 1'b1;
          mul_start_d = 1'b1;   // high for the single ISSUE cycle
          state_d     = ISSUE;
        end
        ISSUE: begin
          state_d = WAIT;
`ifdef SIGNED_MULT_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
        WAIT: begin
          if (mul_rdy) begin
            res_d   = res_fixed;
            state_d = DONE;
          end
`ifdef SIGNED_MULT_TIMEOUT_EN
          // Timeout reports straight away so done lands TIMEOUT_CYCLES after WAIT entry.
          else if (cnt_q == CW'(TIMEOUT_CYCLES-1)) begin
            res_d   = '1;
            done_d  = 1'b1;
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
`endif
        end
        DONE: begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      neg_q       <= 1'b0;
      res_q       <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      mul_start_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
`ifdef SIGNED_MULT_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      neg_q       <= neg_d;
      res_q       <= res_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      mul_start_q <= mul_start_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
`ifdef SIGNED_MULT_TIMEOUT_EN
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign res       = res_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign mul_start = mul_start_q;
  assign mul_dataA = {{N{1'b0}}, mul_a_q};
  assign mul_dataB = {{N{1'b0}}, mul_b_q};
`ifdef SIGNED_MULT_TIMEOUT_EN
  assign err       = err_q;
`endif

endmodule

// File: tb/tb_signed_mult_ctrl.sv
// tb_signed_mult_ctrl: directed vectors with a scoreboard queue; a behavioural
// unsigned core stands in for multiplication_asmd (latency 2 on a zero
// operand, 6 otherwise, rdy one ena cycle wide).
module tb_signed_mult_ctrl;

  localparam int N = 16;
  localparam int W = 2*N;

  logic         clk, rst, ena, start, signed_op;
  logic [W-1:0] dataA, dataB, res, mul_dataA, mul_dataB, mul_res;
  logic         done, busy, mul_start, mul_rdy;
`ifdef SIGNED_MULT_TIMEOUT_EN
  localparam int TO = 4*N+8;
  logic         err;
`endif

  signed_mult_ctrl #(.N(N)) dut (
    .clk(clk), .rst(rst), .ena(ena), .start(start), .signed_op(signed_op),
    .dataA(dataA), .dataB(dataB), .res(res), .done(done), .busy(busy),
`ifdef SIGNED_MULT_TIMEOUT_EN
    .err(err),
`endif
    .mul_start(mul_start), .mul_dataA(mul_dataA), .mul_dataB(mul_dataB),
    .mul_res(mul_res), .mul_rdy(mul_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic         err;
    int           lat;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0, miscompares = 0, ndone = 0, t_accept = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Behavioural core, sharing rst and ena with the DUT.
  logic [W-1:0] core_prod;
  int           core_cnt;
  logic         core_run;
  bit           core_hold = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      mul_rdy  <= 1'b0;
      mul_res  <= '0;
      core_run <= 1'b0;
      core_cnt <= 0;
    end else if (ena) begin
      mul_rdy <= 1'b0;
      if (core_run) begin
        if (core_cnt == 1) begin
          core_run <= 1'b0;
          if (!core_hold) begin
            mul_rdy <= 1'b1;
            mul_res <= core_prod;
          end
        end
        core_cnt <= core_cnt - 1;
      end else if (mul_start) begin
        core_prod <= mul_dataA * mul_dataB;
        core_cnt  <= (mul_dataA == 0 || mul_dataB == 0) ? 2 : 6;
        core_run  <= 1'b1;
      end
    end
  end

  // Monitor: every done pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && ena && done) begin
      ndone++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: res %h with no pending op (cycle %0d)", res, cyc);
      end else begin
        e = exp_q.pop_front();
        check("res", res, e.res);
        check("busy_at_done", W'(busy), W'(0));
        if (e.lat > 0) check("latency", W'(cyc - t_accept), W'(e.lat));
`ifdef SIGNED_MULT_TIMEOUT_EN
        check("err", W'(err), W'(e.err));
`endif
      end
    end
  end

  task automatic issue(input logic s, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [W-1:0] r, input int lat, input logic e);
    exp_t x;
    @(negedge clk);
    signed_op = s;
    dataA     = {16'hA5A5, a};   // junk upper half must be ignored
    dataB     = {16'h5A5A, b};
    start     = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    t_accept = cyc;
    x.res = r; x.err = e; x.lat = lat;
    exp_q.push_back(x);
  endtask

  task automatic wait_done();
    int  n0 = ndone;
    bit  seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ndone != n0) begin seen = 1'b1; break; end
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: no done within 300 cycles (cycle %0d)", cyc);
    end
    @(negedge clk);
    check("done_pulse_width", W'(done), W'(0));
  endtask

  task automatic run_op(input logic s, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [W-1:0] r, input int lat);
    issue(s, a, b, r, lat, 1'b0);
    wait_done();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ena = 1'b1; start = 1'b0; signed_op = 1'b0;
    dataA = '0; dataB = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_res", res, '0);
    check("rst_done", W'(done), W'(0));
    check("rst_busy", W'(busy), W'(0));
    check("rst_mul_start", W'(mul_start), W'(0));
    check("rst_mul_dataA", mul_dataA, '0);
    check("rst_mul_dataB", mul_dataB, '0);

    // 7 * -3 = -21
    issue(1'b1, 16'h0007, 16'hFFFD, 32'hFFFFFFEB, 9, 1'b0);
    check("busy_after_start", W'(busy), W'(1));
    wait_done();

    run_op(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 9);

    // most-negative operand: magnitude 0x8000 reaches the core
    issue(1'b1, 16'h8000, 16'h8000, 32'h40000000, 9, 1'b0);
    check("issue_mul_start", W'(mul_start), W'(1));
    check("issue_mul_dataA", mul_dataA, 32'h00008000);
    check("issue_mul_dataB", mul_dataB, 32'h00008000);
    wait_done();

    run_op(1'b1, 16'h0000, 16'h8000, 32'h00000000, 5);
    run_op(1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001, 9);
    run_op(1'b1, 16'h7FFF, 16'h8000, 32'hC0008000, 9);
    run_op(1'b1, 16'hFFFF, 16'h0000, 32'h00000000, 5);   // no negative zero
    run_op(1'b0, 16'h8000, 16'h0000, 32'h00000000, 5);

    // ena low for 10 cycles in WAIT, then a start inside WAIT is ignored
    issue(1'b1, 16'h0005, 16'hFFFC, 32'hFFFFFFEC, 19, 1'b0);
    @(negedge clk);
    @(negedge clk);
    ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("frozen_busy", W'(busy), W'(1));
    end
    check("frozen_mul_dataA", mul_dataA, 32'h00000005);
    check("frozen_done", W'(done), W'(0));
    ena       = 1'b1;
    signed_op = 1'b0;
    dataA     = 32'd1;
    dataB     = 32'd1;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();
    repeat (15) @(negedge clk);   // any extra done trips the monitor

    // reset in WAIT
    issue(1'b1, 16'h0007, 16'h0003, 32'h00000015, 0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("wait_rst_busy", W'(busy), W'(0));
    check("wait_rst_res", res, '0);
    check("wait_rst_done", W'(done), W'(0));
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    run_op(1'b0, 16'd3, 16'd5, 32'd15, 9);

`ifdef SIGNED_MULT_TIMEOUT_EN
    core_hold = 1'b1;
    issue(1'b1, 16'h0002, 16'h0003, 32'hFFFFFFFF, TO + 1, 1'b1);
    wait_done();
    core_hold = 1'b0;
    run_op(1'b0, 16'd4, 16'd6, 32'd24, 9);
`endif

    repeat (5) @(negedge clk);
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL pending_ops: %0d expected results never seen", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
